// File: rtl/de1_sw_debounce_pkg.sv
// Shared board constants and helpers for the DE1 switch/key input path.
// CLK_HZ is the CLOCK_50 frequency; DEBOUNCE_MS is the tick period, and
// TICK_DIV_DEF is the resulting number of CLOCK_50 cycles per tick.
package de1_sw_debounce_pkg;

  localparam int CLK_HZ           = 50_000_000;
  localparam int DEBOUNCE_MS      = 1;
  localparam int TICK_DIV_DEF     = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int STABLE_TICKS_DEF = 10;

  // Counter width that can hold the values 0..n. It is at least 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/de1_sw_debounce_chan.sv
// One debounced input bit. It contains a 2-flop synchroniser, a tick
// counter that tracks how long the input has disagreed with the stable
// level, the stable level itself, and registered rise/fall pulses.
// Ports:
//   gclk, grst_n : clock and asynchronous active-low reset
//   tick         : shared debounce tick strobe from the prescaler
//   raw          : asynchronous input bit
//   stable       : debounced level
//   rise, fall   : one-cycle pulses that coincide with a change of stable
module de1_sw_debounce_chan
  import de1_sw_debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
  parameter logic RESET_BIT    = 1'b0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(STABLE_TICKS);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      s1     <= RESET_BIT;
      s2     <= RESET_BIT;
      stable <= RESET_BIT;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // The counter is cleared on any cycle where the input agrees with
      // the stable level, so a glitch back discards all progress at once.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(STABLE_TICKS - 1)) begin
          stable <= s2;
          cnt    <= '0;
          rise   <= s2;
          fall   <= ~s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/de1_sw_debounce.sv
// DE1 slide-switch / push-button input conditioner. Each raw input bit is
// synchronised into the CLOCK_50 domain and debounced. For each bit the
// block outputs a clean level plus rise and fall pulses.
// Ports:
//   CLOCK_50  : system clock
//   RST_N     : asynchronous active-low reset
//   SW_IN     : raw board inputs (active-low KEYs must be inverted outside this block)
//   SW_STABLE : debounced levels; held at RESET_VAL during reset
//   SW_RISE   : one-cycle pulse per bit on a 0->1 change of SW_STABLE
//   SW_FALL   : one-cycle pulse per bit on a 1->0 change of SW_STABLE
//   TICK      : one-cycle debounce tick strobe, once every TICK_DIV cycles
module de1_sw_debounce
  import de1_sw_debounce_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter int               TICK_DIV     = TICK_DIV_DEF,
  parameter int               STABLE_TICKS = STABLE_TICKS_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] SW_IN,
  output logic [WIDTH-1:0] SW_STABLE,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             TICK
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] pre;

  // TICK is registered one value early, so it is high during the cycle in
  // which pre holds TICK_DIV-1. The channels consume the tick on the edge
  // where pre wraps to 0.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      pre  <= '0;
      TICK <= 1'b0;
    end else begin
      pre  <= (pre == PW'(TICK_DIV - 1)) ? '0 : pre + PW'(1);
      TICK <= (pre == PW'(TICK_DIV - 2));
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    de1_sw_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_BIT    (RESET_VAL[g])
    ) u_chan (
      .gclk   (CLOCK_50),
      .grst_n (RST_N),
      .tick   (TICK),
      .raw    (SW_IN[g]),
      .stable (SW_STABLE[g]),
      .rise   (SW_RISE[g]),
      .fall   (SW_FALL[g])
    );
  end

endmodule

// File: tb/tb_de1_sw_debounce.sv
// Bench for de1_sw_debounce with TICK_DIV=4, STABLE_TICKS=3 and WIDTH=10.
// Two instances share the same stimulus. One resets to all-zeros and the
// other resets to all-ones. After every edge both instances are compared
// with a behavioural model. The model states the debounce rule as "a bit
// flips on the STABLE_TICKS-th tick edge of an unbroken run of disagreement",
// and it counts ticks arithmetically from the edge index.
module tb_de1_sw_debounce;
  localparam int W  = 10;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] st0, r0, f0, st1, r1, f1;
  logic         tk0, tk1;

  always #5 clk = ~clk;

  de1_sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_VAL(10'h000)) u0 (
    .CLOCK_50(clk), .RST_N(rst_n), .SW_IN(sw_in),
    .SW_STABLE(st0), .SW_RISE(r0), .SW_FALL(f0), .TICK(tk0));
  de1_sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_VAL(10'h3FF)) u1 (
    .CLOCK_50(clk), .RST_N(rst_n), .SW_IN(sw_in),
    .SW_STABLE(st1), .SW_RISE(r1), .SW_FALL(f1), .TICK(tk1));

  // model state
  logic [W-1:0] rv[2];
  logic [W-1:0] m_st[2], m_r[2], m_f[2], p1[2], p2[2];
  int           start[2][W];   // edge index where the current disagreement began, 0 = none
  int           n;             // edges since reset release
  logic         m_tk;
  int           total, bad;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = rv[i]; m_r[i] = '0; m_f[i] = '0; p1[i] = rv[i]; p2[i] = rv[i];
      for (int b = 0; b < W; b++) start[i][b] = 0;
    end
    n = 0; m_tk = 1'b0;
  endtask

  task automatic medge();
    if (!rst_n) return;
    n++;
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < W; b++) begin
        m_r[i][b] = 1'b0; m_f[i][b] = 1'b0;
        if (p2[i][b] == m_st[i][b]) start[i][b] = 0;
        else begin
          if (start[i][b] == 0) start[i][b] = n;
          if ((n % TD == 0) && (n / TD - (start[i][b] - 1) / TD == ST)) begin
            m_st[i][b] = p2[i][b];
            m_r[i][b]  = p2[i][b];
            m_f[i][b]  = ~p2[i][b];
            start[i][b] = 0;
          end
        end
      end
      p2[i] = p1[i]; p1[i] = sw_in;
    end
    m_tk = ((n + 1) % TD == 0);
  endtask

  task automatic cmp_all(input string ph);
    chk({ph, "_stable0"}, st0, m_st[0]);
    chk({ph, "_rise0"},   r0,  m_r[0]);
    chk({ph, "_fall0"},   f0,  m_f[0]);
    chk({ph, "_tick0"},   W'(tk0), W'(m_tk));
    chk({ph, "_stable1"}, st1, m_st[1]);
    chk({ph, "_rise1"},   r1,  m_r[1]);
    chk({ph, "_fall1"},   f1,  m_f[1]);
    chk({ph, "_tick1"},   W'(tk1), W'(m_tk));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    medge();
    #1;
    cmp_all(ph);
  endtask

  task automatic do_reset(input string ph);
    rst_n = 1'b0;
    mreset();
    #1;
    chk({ph, "_rst_stable0"}, st0, 10'h000);
    chk({ph, "_rst_stable1"}, st1, 10'h3FF);
    chk({ph, "_rst_pulses"},  r0 | f0 | r1 | f1, 10'h000);
    chk({ph, "_rst_tick"},    W'(tk0 | tk1), 10'h000);
  endtask

  int ticks, f1_all, r0_any, e0, seen, rcnt, fcnt, lat_ok, glitch;
  logic [W-1:0] st_at, f_at, r_at;

  initial begin
    rv[0] = 10'h000; rv[1] = 10'h3FF;
    total = 0; bad = 0;
    mreset();
    #2;
    do_reset("init");
    repeat (3) step("inrst");

    // idle after release: ticks every TD cycles; all-ones instance falls once
    rst_n = 1'b1;
    ticks = 0; f1_all = 0; r0_any = 0;
    for (int k = 0; k < 100; k++) begin
      step("idle");
      if (tk0) ticks++;
      if (f1 == 10'h3FF) f1_all++;
      if ((r0 | f0) != 0) r0_any++;
    end
    chk("idle_tick_count", W'(ticks), W'(100 / TD));
    chk("resetval_fall_once", W'(f1_all), 10'd1);
    chk("idle_no_pulse0", W'(r0_any), 10'd0);

    // clean rise on bit 0
    sw_in = 10'h001;
    e0 = n + 1; seen = 0; rcnt = 0;
    for (int k = 0; k < 30; k++) begin
      step("rise");
      if (st0[0] && seen == 0) seen = n;
      if (r0 == 10'h001) rcnt++;
    end
    lat_ok = (seen != 0) && (seen - e0 + 1 >= 11) && (seen - e0 + 1 <= 15);
    chk("rise_latency_window", W'(lat_ok), 10'd1);
    chk("rise_pulse_once", W'(rcnt), 10'd1);

    // glitch rejection on bit 3
    glitch = 0;
    sw_in[3] = 1'b1;
    for (int k = 0; k < 9; k++) begin step("glitch"); if (st0[3] || r0[3]) glitch++; end
    sw_in[3] = 1'b0;
    for (int k = 0; k < 20; k++) begin step("glitch"); if (st0[3] || r0[3] || f0[3]) glitch++; end
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) sw_in[3] = ~sw_in[3];
      step("bounce");
      if (st0[3] || r0[3] || f0[3]) glitch++;
    end
    sw_in[3] = 1'b0;
    for (int k = 0; k < 20; k++) begin step("bounce"); if (st0[3] || r0[3] || f0[3]) glitch++; end
    chk("bounce_no_change", W'(glitch), 10'd0);

    // all high, then multi-bit fall to 2AA
    sw_in = 10'h3FF;
    repeat (25) step("allhi");
    chk("allhi_stable", st0, 10'h3FF);
    sw_in = 10'h2AA;
    fcnt = 0; st_at = '0; f_at = '0; r_at = '0;
    for (int k = 0; k < 30; k++) begin
      step("multi");
      if (f0 != 0) begin fcnt++; st_at = st0; f_at = f0; r_at = r0; end
    end
    chk("multi_fall_cycles", W'(fcnt), 10'd1);
    chk("multi_stable_at", st_at, 10'h2AA);
    chk("multi_fall_at", f_at, 10'h155);
    chk("multi_rise_at", r_at, 10'h000);

    // reset mid-count on bit 5
    sw_in = 10'h000;
    repeat (25) step("clr");
    sw_in = 10'h020;
    repeat (10) step("mid");
    do_reset("mid");
    repeat (2) step("midrst");
    rst_n = 1'b1;
    rcnt = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      step("relaunch");
      if (r0 == 10'h020) rcnt++;
      if (st0[5] && seen == 0) seen = n;
    end
    chk("relaunch_rise_once", W'(rcnt), 10'd1);
    chk("relaunch_full_latency", W'((seen >= 11) && (seen <= 15)), 10'd1);

    // random stimulus with occasional resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) sw_in = W'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd");
        step("rndrst");
        rst_n = 1'b1;
      end
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
